romulus_round_sched: RTL

Round scheduler for the Romulus tweakable-block-cipher datapath. It accepts a start request from the mode-level control unit, then runs a fixed number of cipher rounds. Each round spans CLKS_PER_RND clock phases. For every cycle the scheduler generates the round-constant bus, the one-hot round-phase enables and the state/tweakey commit strobes. It presents a held completion handshake and sits between the multi-dimensional API controller and the datapath register enables.

---
 rtl/romulus_round_sched_if.sv | 29 ++
 rtl/romulus_round_sched.sv | 125 ++++++++++++
 2 files changed

// File: rtl/romulus_round_sched_if.sv
// Handshake and datapath-enable bundle between the mode controller and the
// Romulus round scheduler.
interface romulus_round_sched_if #(
    parameter int CLKS_PER_RND = 1,
    parameter int CONSTW       = 6,
    parameter int RNDW         = 6
);
    logic                    start;
    logic                    abort;
    logic                    out_ready;
    logic                    busy;
    logic                    load;
    logic [CLKS_PER_RND-1:0] enrnd;
    logic                    sen;
    logic                    ten;
    logic [CONSTW-1:0]       constant;
    logic [RNDW-1:0]         rnd;
    logic                    out_valid;

    modport master (
        output start, abort, out_ready,
        input  busy, load, enrnd, sen, ten, constant, rnd, out_valid
    );

    modport slave (
        input  start, abort, out_ready,
        output busy, load, enrnd, sen, ten, constant, rnd, out_valid
    );
endinterface

// File: rtl/romulus_round_sched.sv
// Romulus round scheduler: sequences LOAD, ROUNDS x CLKS_PER_RND round phases and
// a held completion handshake. Optional cancel path: define ROMULUS_SCHED_ABORT_EN.
module romulus_round_sched #(
    parameter int ROUNDS       = 40,
    parameter int CLKS_PER_RND = 1,
    parameter int CONSTW       = 6,
    parameter int RNDW         = 6
) (
    input logic                  clk,
    input logic                  rst,
    romulus_round_sched_if.slave bus
);
    localparam int PHW = (CLKS_PER_RND > 1) ? $clog2(CLKS_PER_RND) : 1;
    localparam logic [PHW-1:0]          PH_LAST  = PHW'(CLKS_PER_RND - 1);
    localparam logic [RNDW-1:0]         RND_LAST = RNDW'(ROUNDS - 1);
    localparam logic [CONSTW-1:0]       RC_INIT  = CONSTW'(1);
    localparam logic [CLKS_PER_RND-1:0] EN_FIRST = CLKS_PER_RND'(1);
    localparam logic                    SEN_ON_FIRST = (PH_LAST == '0);

    typedef enum logic [1:0] {IDLE, LOAD, ROUND, HOLD} state_t;

    state_t                  state;
    logic [PHW-1:0]          phase;
    logic [PHW-1:0]          phase_inc;
    logic [CONSTW-1:0]       rc;
    logic [CONSTW-1:0]       rc_next;
    logic [RNDW-1:0]         rnd_q;
    logic                    busy_q;
    logic                    load_q;
    logic                    sen_q;
    logic [CLKS_PER_RND-1:0] enrnd_q;
    logic                    out_valid_q;
    logic                    abort_act;
    logic                    kill;
    logic                    go_load;
    logic                    go_idle;

`ifdef ROMULUS_SCHED_ABORT_EN
    assign abort_act = bus.abort;
`else
    logic unused_abort;
    assign unused_abort = bus.abort;
    assign abort_act    = 1'b0;
`endif

    assign phase_inc = phase + PHW'(1);
    assign rc_next   = {rc[CONSTW-2:0], rc[CONSTW-1] ^ rc[CONSTW-2] ^ 1'b1};

    // abort outranks both start and the completion handshake
    assign kill    = abort_act && (state != IDLE);
    assign go_load = ((state == IDLE) && bus.start && !abort_act) ||
                     ((state == HOLD) && bus.out_ready && bus.start);
    assign go_idle = kill || ((state == HOLD) && bus.out_ready && !bus.start);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            phase       <= '0;
            rc          <= '0;
            rnd_q       <= '0;
            busy_q      <= 1'b0;
            load_q      <= 1'b0;
            sen_q       <= 1'b0;
            enrnd_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            load_q  <= 1'b0;
            sen_q   <= 1'b0;
            enrnd_q <= '0;
            if (go_idle) begin
                state       <= IDLE;
                phase       <= '0;
                rc          <= '0;
                rnd_q       <= '0;
                busy_q      <= 1'b0;
                out_valid_q <= 1'b0;
            end else if (go_load) begin
                state       <= LOAD;
                phase       <= '0;
                rc          <= RC_INIT;
                rnd_q       <= '0;
                busy_q      <= 1'b1;
                load_q      <= 1'b1;
                out_valid_q <= 1'b0;
            end else begin
                // Outputs are set from the upcoming phase so they stay registered.
                case (state)
                    LOAD: begin
                        state   <= ROUND;
                        enrnd_q <= EN_FIRST;
                        sen_q   <= SEN_ON_FIRST;
                    end
                    ROUND: begin
                        if (phase == PH_LAST) begin
                            phase <= '0;
                            rc    <= rc_next;
                            if (rnd_q == RND_LAST) begin
                                state       <= HOLD;
                                out_valid_q <= 1'b1;
                            end else begin
                                rnd_q   <= rnd_q + RNDW'(1);
                                enrnd_q <= EN_FIRST;
                                sen_q   <= SEN_ON_FIRST;
                            end
                        end else begin
                            phase   <= phase_inc;
                            enrnd_q <= enrnd_q << 1;
                            sen_q   <= (phase_inc == PH_LAST);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.load      = load_q;
    assign bus.enrnd     = enrnd_q;
    assign bus.sen       = sen_q;
    assign bus.ten       = sen_q;
    assign bus.constant  = rc;
    assign bus.rnd       = rnd_q;
    assign bus.out_valid = out_valid_q;
endmodule
